pc_sequencer: RTL and testbench

Multicycle fetch/retire sequencer that owns the program counter register's control inputs. It drives the PC write strobe and next-PC value, fetches each instruction from instruction memory with a ready handshake, and presents it to the execute stage. It then applies sequential, branch/jump or trap redirects when the instruction retires. It sits between the program counter register, instruction memory and the decode/execute control.

---
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multicycle fetch/retire sequencer: fetches from instruction memory, holds the
// instruction for execute, then drives the PC register with sequential, redirect or trap targets.
module pc_sequencer #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic        halted,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {FETCH, ISSUE, UPDATE, HALT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc_next;
  logic [31:0] r_instr;
  logic [31:0] r_trap_addr;
  logic [31:0] r_retired_count;
  logic        r_trap_flag;
  logic        w_retire;
  logic        w_misaligned;

  assign w_retire     = (r_state == ISSUE) && instr_ready;
  assign w_misaligned = (redirect_target[1:0] != 2'b00);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:   if (mem_ready) w_state_next = ISSUE;
      ISSUE:   if (instr_ready) w_state_next = halt_req ? HALT : UPDATE;
      UPDATE:  w_state_next = FETCH;
      default: w_state_next = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state         <= FETCH;
      r_pc_next       <= '0;
      r_instr         <= '0;
      r_trap_addr     <= '0;
      r_retired_count <= '0;
      r_trap_flag     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == FETCH && mem_ready) begin
        r_instr <= mem_rdata;
      end
      if (w_retire) begin
        r_retired_count <= r_retired_count + 32'd1;
        // A halting retire leaves pc_next and the trap flag untouched.
        if (!halt_req) begin
          if (redirect_valid && !w_misaligned) begin
            r_pc_next   <= redirect_target;
            r_trap_flag <= 1'b0;
          end else if (redirect_valid) begin
            r_pc_next   <= TRAP_VECTOR;
            r_trap_addr <= redirect_target;
            r_trap_flag <= 1'b1;
          end else begin
            r_pc_next   <= pc + 32'd4;
            r_trap_flag <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    // mem_req is gated by resetn so no fetch is requested while reset is held.
    mem_req       = resetn && (r_state == FETCH);
    mem_addr      = pc;
    instr_valid   = (r_state == ISSUE);
    pc_write      = (r_state == UPDATE);
    trap          = (r_state == UPDATE) && r_trap_flag;
    halted        = (r_state == HALT);
    pc_next       = r_pc_next;
    instr         = r_instr;
    trap_addr     = r_trap_addr;
    retired_count = r_retired_count;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        trap;
  logic [31:0] trap_addr;
  logic        halted;
  logic [31:0] retired_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pc_sequencer #(.TRAP_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .resetn(resetn), .pc(pc), .pc_write(pc_write), .pc_next(pc_next),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .halt_req(halt_req),
    .trap(trap), .trap_addr(trap_addr), .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Program counter register owned by the environment.
  always @(posedge clk) begin
    if (!resetn) pc <= '0;
    else if (pc_write) pc <= pc_next;
  end

  // Behavioural model: which activity the sequencer is busy with, plus the values it holds.
  bit          m_valid = 0;
  bit          m_fetching, m_holding, m_updating, m_stopped, m_trap_pending;
  logic [31:0] m_pc, m_pc_next, m_instr, m_trap_addr, m_count;

  task automatic model_edge();
    if (!resetn) begin
      m_valid = 1; m_fetching = 1; m_holding = 0; m_updating = 0; m_stopped = 0;
      m_trap_pending = 0; m_pc = 0; m_pc_next = 0; m_instr = 0; m_trap_addr = 0; m_count = 0;
    end else if (m_valid) begin
      if (m_updating) begin
        m_pc = m_pc_next; m_updating = 0; m_fetching = 1;
      end else if (m_fetching) begin
        if (mem_ready) begin m_instr = mem_rdata; m_fetching = 0; m_holding = 1; end
      end else if (m_holding && instr_ready) begin
        m_count = m_count + 1; m_holding = 0;
        if (halt_req) m_stopped = 1;
        else begin
          m_updating = 1;
          if (!redirect_valid) begin
            m_pc_next = m_pc + 4; m_trap_pending = 0;
          end else if (redirect_target % 4 == 0) begin
            m_pc_next = redirect_target; m_trap_pending = 0;
          end else begin
            m_pc_next = 32'h100; m_trap_addr = redirect_target; m_trap_pending = 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("mem_req",       {31'b0, mem_req},     {31'b0, resetn && m_fetching});
    chk("mem_addr",      mem_addr,             m_pc);
    chk("instr_valid",   {31'b0, instr_valid}, {31'b0, m_holding});
    chk("pc_write",      {31'b0, pc_write},    {31'b0, m_updating});
    chk("trap",          {31'b0, trap},        {31'b0, m_updating && m_trap_pending});
    chk("halted",        {31'b0, halted},      {31'b0, m_stopped});
    chk("pc_next",       pc_next,              m_pc_next);
    chk("instr",         instr,                m_instr);
    chk("trap_addr",     trap_addr,            m_trap_addr);
    chk("retired_count", retired_count,        m_count);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (m_valid) compare();
  endtask

  int unsigned mreq_seen;
  logic [31:0] t;

  initial begin
    resetn = 0; mem_ready = 0; mem_rdata = 0; instr_ready = 0;
    redirect_valid = 0; redirect_target = 0; halt_req = 0;
    #1;
    step(); step();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_pc_write", {31'b0, pc_write}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_count", retired_count, 32'd0);
    chk("rst_pc_next", pc_next, 32'd0);

    // Sequential run, zero-wait memory, execute always ready.
    resetn = 1; mem_ready = 1; instr_ready = 1; mem_rdata = 32'h0000_0013;
    #1;
    chk("seq_c1_mem_req", {31'b0, mem_req}, 32'd1);
    chk("seq_c1_addr", mem_addr, 32'h0);
    for (int unsigned i = 2; i <= 9; i++) begin
      step();
      if (i == 3) chk("seq_c3_pc_write", {31'b0, pc_write}, 32'd1);
      if (i == 4) chk("seq_c4_addr", mem_addr, 32'h4);
      if (i == 6) chk("seq_c6_pc_write", {31'b0, pc_write}, 32'd1);
      if (i == 7) chk("seq_c7_addr", mem_addr, 32'h8);
      if (i == 9) chk("seq_c9_count", retired_count, 32'd3);
    end

    // Memory wait states at pc 0xC.
    mem_ready = 0; instr_ready = 0;
    mreq_seen = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      if (mem_req) mreq_seen++;
    end
    mem_ready = 1; mem_rdata = 32'h0050_0093;
    step();
    chk("wait_mem_req_cycles", mreq_seen, 32'd5);
    chk("wait_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("wait_instr", instr, 32'h0050_0093);

    // Retire 0xC sequentially, then aligned redirect from 0x10.
    instr_ready = 1;
    step(); step();
    chk("redir_fetch_addr", mem_addr, 32'h10);
    step();
    redirect_valid = 1; redirect_target = 32'h40;
    step();
    chk("redir_pc_next", pc_next, 32'h40);
    chk("redir_pc_write", {31'b0, pc_write}, 32'd1);
    chk("redir_trap", {31'b0, trap}, 32'd0);
    redirect_valid = 0;
    step();
    chk("redir_next_addr", mem_addr, 32'h40);

    // Misaligned redirect traps to the vector.
    step();
    redirect_valid = 1; redirect_target = 32'h42;
    step();
    chk("mis_pc_next", pc_next, 32'h100);
    chk("mis_trap", {31'b0, trap}, 32'd1);
    chk("mis_pc_write", {31'b0, pc_write}, 32'd1);
    chk("mis_trap_addr", trap_addr, 32'h42);
    redirect_valid = 0;
    step();
    chk("mis_next_addr", mem_addr, 32'h100);

    // PC wrap from 0xFFFFFFFC.
    step();
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 0;
    step();
    chk("wrap_fetch_addr", mem_addr, 32'hFFFF_FFFC);
    step(); step();
    chk("wrap_pc_next", pc_next, 32'h0);
    chk("wrap_trap", {31'b0, trap}, 32'd0);
    step();
    chk("wrap_next_addr", mem_addr, 32'h0);

    // Halt has priority over a simultaneous redirect.
    step();
    halt_req = 1; redirect_valid = 1; redirect_target = 32'h80;
    step();
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_pc_write", {31'b0, pc_write}, 32'd0);
    chk("halt_count", retired_count, 32'd9);
    halt_req = 0; redirect_valid = 0;
    mreq_seen = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      if (mem_req || pc_write) mreq_seen++;
    end
    chk("halt_quiet_cycles", mreq_seen, 32'd0);
    resetn = 0;
    step();
    chk("halt_rst_halted", {31'b0, halted}, 32'd0);
    chk("halt_rst_count", retired_count, 32'd0);
    resetn = 1;
    #1;
    chk("halt_rst_mem_req", {31'b0, mem_req}, 32'd1);
    chk("halt_rst_addr", mem_addr, 32'h0);

    // Randomized traffic including occasional resets and halts.
    for (int unsigned i = 0; i < 3000; i++) begin
      step();
      mem_ready      = ($urandom_range(0, 3) != 0);
      mem_rdata      = $urandom;
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = $urandom_range(0, 1);
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      redirect_target = t;
      halt_req       = ($urandom_range(0, 39) == 0);
      resetn         = m_stopped ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 149) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
